// File: rtl/uart_regs_pkg.sv
// uart_regs_pkg: shared constants for the UART APB register block.
//   Word-aligned register offsets, STATUS and IEN bit positions, and the
//   depth of the transmit push credit counter.
package uart_regs_pkg;

  localparam logic [3:0] ADDR_DATA   = 4'h0;
  localparam logic [3:0] ADDR_STATUS = 4'h4;
  localparam logic [3:0] ADDR_DIV    = 4'h8;
  localparam logic [3:0] ADDR_IEN    = 4'hC;

  localparam int STAT_RX_AVAIL = 0;
  localparam int STAT_TX_BUSY  = 1;
  localparam int STAT_TXDONE   = 2;
  localparam int STAT_TX_FULL  = 3;

  localparam int IEN_RX     = 0;
  localparam int IEN_TXDONE = 1;

  localparam logic [1:0] TX_DEPTH = 2'd2;

endpackage

// File: rtl/uart_regs.sv
// uart_regs: APB register front end for a UART core.
//   clk, rst_n                : clock, async active-low reset
//   psel/penable/pwrite/paddr/pwdata/prdata/pready/pslverr : APB slave
//   tx_byte, tx_valid, tx_done : transmit push interface to the core
//   rx_byte, rx_irq, rxfifo_ren_ext : receive FIFO head / non-empty / pop
//   div_int, div_frac          : baud divisor
//   irq                        : registered level interrupt
module uart_regs
  import uart_regs_pkg::*;
#(
  parameter logic [9:0] DIV_INT_RST  = 10'd27,
  parameter logic [3:0] DIV_FRAC_RST = 4'd0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        psel,
  input  logic        penable,
  input  logic        pwrite,
  input  logic [3:0]  paddr,
  input  logic [31:0] pwdata,
  output logic [31:0] prdata,
  output logic        pready,
  output logic        pslverr,
  output logic [7:0]  tx_byte,
  output logic        tx_valid,
  input  logic        tx_done,
  input  logic [7:0]  rx_byte,
  input  logic        rx_irq,
  output logic        rxfifo_ren_ext,
  output logic [9:0]  div_int,
  output logic [3:0]  div_frac,
  output logic        irq
);

  logic       access;
  logic [3:0] addr_word;
  logic       tx_done_q;
  logic       tx_done_rise;
  logic [1:0] tx_pend;
  logic       tx_full;
  logic       txdone_sticky;
  logic [1:0] ien;
  logic [31:0] status;
  logic       tx_push;
  logic       sticky_clr;
  logic       div_wr;
  logic       ien_wr;

  // rst_n gates the access so the combinational pop pulse stays low in reset.
  assign access       = psel & penable & rst_n;
  assign addr_word    = {paddr[3:2], 2'b00};
  assign tx_done_rise = tx_done & ~tx_done_q;
  assign tx_full      = (tx_pend == TX_DEPTH);
  assign pready       = 1'b1;

  always_comb begin
    status                = '0;
    status[STAT_RX_AVAIL] = rx_irq;
    status[STAT_TX_BUSY]  = (tx_pend != 2'd0);
    status[STAT_TXDONE]   = txdone_sticky;
    status[STAT_TX_FULL]  = tx_full;
  end

  always_comb begin
    prdata         = '0;
    pslverr        = 1'b0;
    rxfifo_ren_ext = 1'b0;
    tx_push        = 1'b0;
    sticky_clr     = 1'b0;
    div_wr         = 1'b0;
    ien_wr         = 1'b0;
    if (access) begin
      case (addr_word)
        ADDR_DATA: begin
          if (pwrite) begin
            if (tx_full) pslverr = 1'b1;
            else         tx_push = 1'b1;
          end else if (rx_irq) begin
            prdata         = {24'b0, rx_byte};
            rxfifo_ren_ext = 1'b1;
          end else begin
            pslverr = 1'b1;
          end
        end
        ADDR_STATUS: begin
          if (pwrite) sticky_clr = pwdata[STAT_TXDONE];
          else        prdata     = status;
        end
        ADDR_DIV: begin
          if (pwrite) div_wr = 1'b1;
          else        prdata = {18'b0, div_frac, div_int};
        end
        ADDR_IEN: begin
          if (pwrite) ien_wr = 1'b1;
          else        prdata = {30'b0, ien};
        end
        default: pslverr = 1'b1;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_done_q     <= 1'b0;
      tx_pend       <= 2'd0;
      tx_byte       <= 8'd0;
      tx_valid      <= 1'b0;
      txdone_sticky <= 1'b0;
      div_int       <= DIV_INT_RST;
      div_frac      <= DIV_FRAC_RST;
      ien           <= 2'b0;
      irq           <= 1'b0;
    end else begin
      tx_done_q <= tx_done;
      tx_valid  <= tx_push;
      if (tx_push) tx_byte <= pwdata[7:0];

      // Simultaneous push and completion cancel; completion never underflows.
      if (tx_push && !tx_done_rise)
        tx_pend <= tx_pend + 2'd1;
      else if (!tx_push && tx_done_rise && tx_pend != 2'd0)
        tx_pend <= tx_pend - 2'd1;

      if (tx_done_rise)    txdone_sticky <= 1'b1;
      else if (sticky_clr) txdone_sticky <= 1'b0;

      if (div_wr) begin
        div_int  <= pwdata[9:0];
        div_frac <= pwdata[13:10];
      end
      if (ien_wr) ien <= pwdata[1:0];

      irq <= (ien[IEN_RX] & rx_irq) | (ien[IEN_TXDONE] & txdone_sticky);
    end
  end

endmodule

// File: tb/tb_uart_regs.sv
module tb_uart_regs;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        psel = 1'b0;
  logic        penable = 1'b0;
  logic        pwrite = 1'b0;
  logic [3:0]  paddr = '0;
  logic [31:0] pwdata = '0;
  logic [31:0] prdata;
  logic        pready;
  logic        pslverr;
  logic [7:0]  tx_byte;
  logic        tx_valid;
  logic        tx_done = 1'b0;
  logic [7:0]  rx_byte = '0;
  logic        rx_irq = 1'b0;
  logic        rxfifo_ren_ext;
  logic [9:0]  div_int;
  logic [3:0]  div_frac;
  logic        irq;

  int vec_cnt = 0;
  int err_cnt = 0;
  int txv_cnt = 0;
  int pop_cnt = 0;

  uart_regs dut (
    .clk(clk), .rst_n(rst_n), .psel(psel), .penable(penable), .pwrite(pwrite),
    .paddr(paddr), .pwdata(pwdata), .prdata(prdata), .pready(pready),
    .pslverr(pslverr), .tx_byte(tx_byte), .tx_valid(tx_valid), .tx_done(tx_done),
    .rx_byte(rx_byte), .rx_irq(rx_irq), .rxfifo_ren_ext(rxfifo_ren_ext),
    .div_int(div_int), .div_frac(div_frac), .irq(irq)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (tx_valid) txv_cnt++;
    if (rxfifo_ren_ext) pop_cnt++;
  end

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  task automatic apb_write(input logic [3:0] a, input logic [31:0] d, output logic err);
    @(negedge clk);
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = a; pwdata = d;
    @(negedge clk);
    penable = 1'b1;
    #1 err = pslverr;
    @(negedge clk);
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
  endtask

  task automatic apb_read(input logic [3:0] a, output logic [31:0] d, output logic err);
    @(negedge clk);
    psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = a;
    @(negedge clk);
    penable = 1'b1;
    #1 begin d = prdata; err = pslverr; end
    @(negedge clk);
    psel = 1'b0; penable = 1'b0;
  endtask

  task automatic pulse_tx_done(input int n);
    @(negedge clk); tx_done = 1'b1;
    idle(n);
    tx_done = 1'b0;
    idle(2);
  endtask

  task automatic test_reset;
    logic [31:0] d; logic e;
    idle(2);
    vec_cnt++;
    if (tx_valid !== 1'b0 || irq !== 1'b0 || tx_byte !== 8'h00 || rxfifo_ren_ext !== 1'b0) begin
      err_cnt++; $display("FAIL reset_outs: got txv=%b irq=%b txb=%h pop=%b want 0", tx_valid, irq, tx_byte, rxfifo_ren_ext);
    end
    vec_cnt++;
    if (div_int !== 10'd27 || div_frac !== 4'd0 || pready !== 1'b1) begin
      err_cnt++; $display("FAIL reset_div: got %0d/%0d rdy=%b want 27/0 rdy=1", div_int, div_frac, pready);
    end
    @(negedge clk); rst_n = 1'b1;
    apb_read(4'h8, d, e);
    vec_cnt++;
    if (d !== 32'h1B || e !== 1'b0) begin err_cnt++; $display("FAIL reset_rd_div: got %h err=%b want 0000001b", d, e); end
    apb_read(4'hC, d, e);
    vec_cnt++;
    if (d !== 32'h0) begin err_cnt++; $display("FAIL reset_rd_ien: got %h want 0", d); end
    apb_read(4'h4, d, e);
    vec_cnt++;
    if (d !== 32'h0) begin err_cnt++; $display("FAIL reset_rd_status: got %h want 0", d); end
  endtask

  task automatic test_tx;
    logic [31:0] d; logic e; int t0;
    t0 = txv_cnt;
    apb_write(4'h0, 32'h0000_00A5, e);
    idle(2);
    vec_cnt++;
    if (e !== 1'b0 || tx_byte !== 8'hA5 || txv_cnt - t0 !== 1) begin
      err_cnt++; $display("FAIL tx_push: got err=%b byte=%h pulses=%0d want 0/a5/1", e, tx_byte, txv_cnt - t0);
    end
    apb_read(4'h4, d, e);
    vec_cnt++;
    if (d !== 32'h2) begin err_cnt++; $display("FAIL tx_busy_status: got %h want 2", d); end
    pulse_tx_done(5);
    apb_read(4'h4, d, e);
    vec_cnt++;
    if (d !== 32'h4) begin err_cnt++; $display("FAIL tx_done_status: got %h want 4", d); end
    apb_write(4'h4, 32'h4, e);
    apb_read(4'h4, d, e);
    vec_cnt++;
    if (d !== 32'h0) begin err_cnt++; $display("FAIL w1c_status: got %h want 0", d); end
  endtask

  task automatic test_tx_full;
    logic [31:0] d; logic e0, e1, e2, e; int t0;
    t0 = txv_cnt;
    apb_write(4'h0, 32'h11, e0);
    apb_write(4'h0, 32'h22, e1);
    apb_write(4'h0, 32'h33, e2);
    idle(2);
    vec_cnt++;
    if (e0 !== 1'b0 || e1 !== 1'b0 || e2 !== 1'b1) begin
      err_cnt++; $display("FAIL full_err: got %b%b%b want 001", e0, e1, e2);
    end
    vec_cnt++;
    if (txv_cnt - t0 !== 2 || tx_byte !== 8'h22) begin
      err_cnt++; $display("FAIL full_pulses: got %0d byte=%h want 2/22", txv_cnt - t0, tx_byte);
    end
    apb_read(4'h4, d, e);
    vec_cnt++;
    if (d !== 32'hA) begin err_cnt++; $display("FAIL full_status: got %h want a", d); end
    pulse_tx_done(1);
    apb_read(4'h4, d, e);
    vec_cnt++;
    if (d !== 32'h6) begin err_cnt++; $display("FAIL drain1_status: got %h want 6", d); end
    pulse_tx_done(1);
    pulse_tx_done(1);
    apb_read(4'h4, d, e);
    vec_cnt++;
    if (d !== 32'h4) begin err_cnt++; $display("FAIL drain_underflow: got %h want 4", d); end
    apb_write(4'h4, 32'h4, e);
  endtask

  task automatic test_rx;
    logic [31:0] d; logic e; int p0;
    @(negedge clk); rx_irq = 1'b1; rx_byte = 8'h3C;
    p0 = pop_cnt;
    apb_read(4'h0, d, e);
    idle(1);
    vec_cnt++;
    if (d !== 32'h3C || e !== 1'b0 || pop_cnt - p0 !== 1) begin
      err_cnt++; $display("FAIL rx_read: got %h err=%b pops=%0d want 3c/0/1", d, e, pop_cnt - p0);
    end
    p0 = pop_cnt;
    apb_read(4'h4, d, e);
    idle(1);
    vec_cnt++;
    if (d !== 32'h1 || pop_cnt - p0 !== 0) begin
      err_cnt++; $display("FAIL rx_status: got %h pops=%0d want 1/0", d, pop_cnt - p0);
    end
    @(negedge clk); rx_irq = 1'b0;
    p0 = pop_cnt;
    apb_read(4'h0, d, e);
    idle(1);
    vec_cnt++;
    if (d !== 32'h0 || e !== 1'b1 || pop_cnt - p0 !== 0) begin
      err_cnt++; $display("FAIL rx_empty: got %h err=%b pops=%0d want 0/1/0", d, e, pop_cnt - p0);
    end
  endtask

  task automatic test_irq;
    logic [31:0] d; logic e;
    apb_write(4'hC, 32'h3, e);
    apb_read(4'hC, d, e);
    vec_cnt++;
    if (d !== 32'h3) begin err_cnt++; $display("FAIL ien_rd: got %h want 3", d); end
    @(negedge clk); rx_irq = 1'b1;
    #1;
    vec_cnt++;
    if (irq !== 1'b0) begin err_cnt++; $display("FAIL irq_not_early: got %b want 0", irq); end
    @(negedge clk);
    vec_cnt++;
    if (irq !== 1'b1) begin err_cnt++; $display("FAIL irq_rx: got %b want 1", irq); end
    rx_irq = 1'b0;
    @(negedge clk);
    vec_cnt++;
    if (irq !== 1'b0) begin err_cnt++; $display("FAIL irq_rx_drop: got %b want 0", irq); end
    pulse_tx_done(1);
    idle(3);
    vec_cnt++;
    if (irq !== 1'b1) begin err_cnt++; $display("FAIL irq_txdone: got %b want 1", irq); end
    apb_write(4'h4, 32'h4, e);
    idle(2);
    vec_cnt++;
    if (irq !== 1'b0) begin err_cnt++; $display("FAIL irq_w1c: got %b want 0", irq); end
    apb_write(4'hC, 32'h0, e);
  endtask

  task automatic test_div;
    logic [31:0] d; logic e;
    apb_write(4'h8, 32'h0000_2C05, e);
    @(negedge clk);
    vec_cnt++;
    if (div_int !== 10'd5 || div_frac !== 4'hB) begin
      err_cnt++; $display("FAIL div_wr: got %0d/%h want 5/b", div_int, div_frac);
    end
    apb_read(4'h8, d, e);
    vec_cnt++;
    if (d !== 32'h2C05) begin err_cnt++; $display("FAIL div_rd: got %h want 2c05", d); end
    apb_write(4'hB, 32'hFFFF_FFFF, e);
    apb_read(4'h9, d, e);
    vec_cnt++;
    if (d !== 32'h3FFF) begin err_cnt++; $display("FAIL div_alias: got %h want 3fff", d); end
  endtask

  task automatic test_setup_only;
    int t0;
    t0 = txv_cnt;
    @(negedge clk);
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 4'h8; pwdata = 32'h0000_0001;
    #1;
    vec_cnt++;
    if (pslverr !== 1'b0 || prdata !== 32'h0) begin
      err_cnt++; $display("FAIL setup_err: got err=%b rd=%h want 0/0", pslverr, prdata);
    end
    idle(2);
    paddr = 4'h0;
    idle(2);
    psel = 1'b0; pwrite = 1'b0;
    idle(2);
    vec_cnt++;
    if (div_int !== 10'h3FF || div_frac !== 4'hF || txv_cnt - t0 !== 0) begin
      err_cnt++; $display("FAIL setup_effect: got div=%h/%h pulses=%0d want 3ff/f/0", div_int, div_frac, txv_cnt - t0);
    end
  endtask

  task automatic test_reset_mid_access;
    int t0;
    t0 = txv_cnt;
    @(negedge clk);
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 4'h0; pwdata = 32'h77;
    @(negedge clk);
    penable = 1'b1; rst_n = 1'b0;
    @(negedge clk);
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    rst_n = 1'b1;
    idle(3);
    vec_cnt++;
    if (txv_cnt - t0 !== 0 || tx_byte !== 8'h00 || div_int !== 10'd27) begin
      err_cnt++; $display("FAIL mid_reset: got pulses=%0d byte=%h div=%0d want 0/00/27", txv_cnt - t0, tx_byte, div_int);
    end
  endtask

  initial begin
    test_reset;
    test_tx;
    test_tx_full;
    test_rx;
    test_irq;
    test_div;
    test_setup_only;
    test_reset_mid_access;
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule

// File: doc/uart_regs.md
UART_REGS -- requirements
Module: uart_regs

Interface
REQ-001 SHALL have parameter DIV_INT_RST, default 10'd27, meaning reset value of the integer baud divisor.
REQ-002 SHALL have parameter DIV_FRAC_RST, default 4'd0, meaning reset value of the fractional baud divisor.
REQ-003 SHALL use one clock, clk, with reset rst_n asynchronous and active-low.
REQ-004 SHALL have these ports (name direction width meaning):
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- psel  in  1  APB select
- penable  in  1  APB access phase
- pwrite  in  1  APB write
- paddr  in  4  byte address; bits [1:0] are ignored
- pwdata  in  32  write data
- prdata  out  32  read data
- pready  out  1  constant 1, so every access has zero wait states
- pslverr  out  1  error flag, valid in the access phase
- tx_byte  out  8  byte to transmit
- tx_valid  out  1  one-cycle transmit push pulse
- tx_done  in  1  core level, high during the last transmitted bit
- rx_byte  in  8  head of the core receive FIFO
- rx_irq  in  1  core receive FIFO not empty
- rxfifo_ren_ext  out  1  one-cycle receive FIFO pop pulse
- div_int  out  10  integer baud divisor
- div_frac  out  4  fractional baud divisor
- irq  out  1  level interrupt

Function
REQ-005 An access SHALL occur only in the cycle where psel=1 and penable=1; all side effects SHALL happen in that cycle.
REQ-006 The register map SHALL be:
- 0x0 DATA
- 0x4 STATUS
- 0x8 DIV: [9:0] int, [13:10] frac
- 0xC IEN: [0] rx, [1] txdone
- any other address: pslverr=1, prdata=0, no side effect.
REQ-007 A DATA write with tx_pend<2 SHALL:
- drive tx_byte=pwdata[7:0] from a register,
- pulse tx_valid for exactly one cycle after the access,
- increment tx_pend.
REQ-008 A DATA write with tx_pend==2 SHALL set pslverr=1, drop the byte, and issue no tx_valid.
REQ-009 tx_pend (0..2) SHALL decrement on each rising edge of tx_done, detected with a registered copy of tx_done. On a simultaneous increment and decrement it SHALL stay unchanged, and it SHALL never underflow below 0.
REQ-010 A DATA read with rx_irq=1 SHALL return {24'b0, rx_byte} and pulse rxfifo_ren_ext in that same cycle.
REQ-011 A DATA read with rx_irq=0 SHALL return 0, set pslverr=1, and issue no pop.
REQ-012 STATUS SHALL read as:
- [0] rx_irq
- [1] tx_pend!=0
- [2] txdone_sticky
- [3] tx_pend==2
- all other bits 0.
REQ-013 txdone_sticky SHALL set on a tx_done rising edge and clear when a STATUS write has pwdata[2]=1 (write-1-to-clear). When set and clear coincide, set SHALL win.
REQ-014 A DIV write SHALL update div_int and div_frac on the next clock; a DIV read SHALL return the current values.
REQ-015 An IEN write SHALL store pwdata[1:0]; an IEN read SHALL return them.
REQ-016 irq SHALL be registered: irq = (ien[0] & rx_irq) | (ien[1] & txdone_sticky), appearing one cycle late.
REQ-017 psel without penable (setup phase) SHALL cause no side effect.
REQ-018 pslverr SHALL be 0 outside an access.

Reset
REQ-019 While rst_n=0, outputs and state SHALL be:
- tx_valid=0, rxfifo_ren_ext=0, tx_byte=0, irq=0
- div_int=DIV_INT_RST, div_frac=DIV_FRAC_RST
- ien=0, tx_pend=0, txdone_sticky=0, tx_done edge register=0.
REQ-020 Reset asserted mid-access SHALL abandon that access, with no pulse issued after reset deasserts.

Structure
REQ-021 The shared package uart_regs_pkg SHALL hold the address offsets, STATUS bit indices, IEN bit indices, and the TX_DEPTH=2 constant.
REQ-022 The block SHALL be a single module with no sub-module; the edge detector SHALL be inline.

Verification
REQ-023 Reset, then read DIV -> 0x0000001B; read IEN -> 0; read STATUS -> 0.
REQ-024 Write DATA=0xA5 -> tx_byte=0xA5 with one tx_valid pulse and STATUS[1]=1. Then give a 5-cycle tx_done high pulse -> STATUS=0x4; write STATUS=0x4 -> STATUS=0.
REQ-025 Three DATA writes with no tx_done -> third write returns pslverr=1 with only 2 tx_valid pulses; STATUS[3]=1.
REQ-026 With rx_irq=1 and rx_byte=0x3C, read DATA -> prdata=0x3C with one rxfifo_ren_ext pulse. With rx_irq=0, read DATA -> pslverr=1 and no pop.
REQ-027 Write IEN=0x3, then raise rx_irq -> irq=1 one cycle later. Drop rx_irq -> irq=0. Pulse tx_done -> irq=1 until STATUS W1C.
REQ-028 Write DIV=0x2C05 -> div_int=5 and div_frac=0xB; access to address 0x10&0xF aliasing is excluded; setup-only psel -> no state change.
